// File: rtl/shift_pkg.sv
// Shared definitions for the serial shift unit.
//   op_e    : operation encodings as seen on the op port
//   state_e : control states of the serial shifter
package shift_pkg;

    typedef enum logic [1:0] {
        OP_SLL  = 2'b00,
        OP_SRL  = 2'b01,
        OP_SRA  = 2'b10,
        OP_ROTR = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_e;

endpackage

// File: rtl/shift_step.sv
// Combinational single-step shifter: shifts acc_i by k_i bit positions
// (0..STEP) according to op_i.
//   acc_i  : current accumulator
//   op_i   : operation (sll/srl/sra/rotr)
//   fill_i : fill bit used by sra (sign of the original operand)
//   k_i    : step amount for this cycle
//   acc_o  : shifted accumulator
module shift_step
    import shift_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned KW    = 1
) (
    input  logic [WIDTH-1:0] acc_i,
    input  op_e              op_i,
    input  logic             fill_i,
    input  logic [KW-1:0]    k_i,
    output logic [WIDTH-1:0] acc_o
);

    localparam logic [WIDTH-1:0] ONES = '1;

    always_comb begin
        acc_o = acc_i;
        unique case (op_i)
            OP_SLL:  acc_o = acc_i << k_i;
            OP_SRL:  acc_o = acc_i >> k_i;
            // Top k bits are forced to the fill bit.
            OP_SRA:  acc_o = (acc_i >> k_i) | (~(ONES >> k_i) & {WIDTH{fill_i}});
            // k_i==0 makes the left shift WIDTH wide, which yields zero.
            OP_ROTR: acc_o = (acc_i >> k_i) | (acc_i << (WIDTH - k_i));
            default: acc_o = acc_i;
        endcase
    end

endmodule

// File: rtl/serial_shift_unit.sv
// Multi-cycle shift unit: performs sll/srl/sra/rotr on a WIDTH-bit operand,
// STEP bits per cycle, with a start/busy/done handshake.
//   clk    : rising-edge clock
//   resetn : asynchronous active-low reset
//   start  : request, accepted in IDLE or DONE when flush is low
//   op     : 00 sll, 01 srl, 10 sra, 11 rotr
//   sa     : shift amount, latched on accepted start
//   din    : operand, latched on accepted start
//   flush  : synchronous abort, has priority over start
//   busy   : high while shifting
//   done   : one-cycle pulse when dout is updated
//   dout   : last completed result
module serial_shift_unit
    import shift_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SAW   = 5,
    parameter int unsigned STEP  = 1
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [SAW-1:0]   sa,
    input  logic [WIDTH-1:0] din,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] dout
);

    localparam int unsigned KW = $clog2(STEP + 1);

    state_e           state_q;
    op_e              op_q;
    logic             fill_q;
    logic [WIDTH-1:0] acc_q;
    logic [SAW-1:0]   cnt_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] dout_q;

    logic [KW-1:0]    k;
    logic [WIDTH-1:0] acc_d;
    logic [SAW-1:0]   cnt_d;

    // k = min(STEP, cnt); when k==STEP exceeds the SAW range, cnt < STEP,
    // so the truncating cast in cnt_d never sees k==STEP.
    always_comb begin
        if (32'(cnt_q) >= 32'(STEP)) begin
            k = KW'(STEP);
        end else begin
            k = KW'(cnt_q);
        end
        cnt_d = cnt_q - SAW'(k);
    end

    shift_step #(
        .WIDTH (WIDTH),
        .KW    (KW)
    ) u_step (
        .acc_i  (acc_q),
        .op_i   (op_q),
        .fill_i (fill_q),
        .k_i    (k),
        .acc_o  (acc_d)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            op_q    <= OP_SLL;
            fill_q  <= 1'b0;
            acc_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dout_q  <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (flush || !start) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        acc_q  <= din;
                        cnt_q  <= sa;
                        op_q   <= op_e'(op);
                        fill_q <= din[WIDTH-1];
                        if (sa == '0) begin
                            // Zero shift completes on the accepting edge.
                            state_q <= ST_DONE;
                            dout_q  <= din;
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q <= ST_SHIFT;
                            busy_q  <= 1'b1;
                        end
                    end
                end
                ST_SHIFT: begin
                    if (flush) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        acc_q <= acc_d;
                        cnt_q <= cnt_d;
                        if (cnt_d == '0) begin
                            state_q <= ST_DONE;
                            dout_q  <= acc_d;
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign dout = dout_q;

endmodule

// File: tb/tb_serial_shift_unit.sv
// Directed bench for serial_shift_unit: one STEP=1 and one STEP=4 instance,
// with hand-computed expected results.
module tb_serial_shift_unit;

    logic        clk;
    logic        resetn;
    logic        start1;
    logic        start4;
    logic        flush;
    logic [1:0]  op;
    logic [4:0]  sa;
    logic [31:0] din;
    logic        busy1, done1, busy4, done4;
    logic [31:0] dout1, dout4;

    int vectors;
    int miscompares;

    serial_shift_unit #(
        .WIDTH (32),
        .SAW   (5),
        .STEP  (1)
    ) u_dut1 (
        .clk    (clk),
        .resetn (resetn),
        .start  (start1),
        .op     (op),
        .sa     (sa),
        .din    (din),
        .flush  (flush),
        .busy   (busy1),
        .done   (done1),
        .dout   (dout1)
    );

    serial_shift_unit #(
        .WIDTH (32),
        .SAW   (5),
        .STEP  (4)
    ) u_dut4 (
        .clk    (clk),
        .resetn (resetn),
        .start  (start4),
        .op     (op),
        .sa     (sa),
        .din    (din),
        .flush  (flush),
        .busy   (busy4),
        .done   (done4),
        .dout   (dout4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle 1ns past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a request for exactly one edge (edge 1), return 1ns after it.
    task automatic go(input bit sel4, input logic [1:0] o, input logic [4:0] s,
                      input logic [31:0] d);
        op  = o;
        sa  = s;
        din = d;
        if (sel4) start4 = 1'b1; else start1 = 1'b1;
        tick();
        start1 = 1'b0;
        start4 = 1'b0;
        din    = 32'h5A5A_0F0F;  // operands may change after acceptance
        sa     = 5'd3;
        op     = 2'b11;
    endtask

    // Count edges until done is seen, bounded at 100 edges.
    task automatic wait_done(input bit sel4, input int first, output int edges);
        edges = first;
        while (!(sel4 ? done4 : done1) && edges < 100) begin
            tick();
            edges++;
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        #2;
        vectors++;
        if ({busy1, done1, busy4, done4} !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_flags: got %b, expected 0000", {busy1, done1, busy4, done4});
        end
        vectors++;
        if (dout1 !== 32'h0 || dout4 !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_dout: got %h/%h, expected 0/0", dout1, dout4);
        end
        tick();
        tick();
        #2 resetn = 1'b1;
        tick();
    endtask

    task automatic test_sll();
        go(1'b0, 2'b00, 5'd4, 32'h0000_0001);
        for (int i = 1; i <= 4; i++) begin
            if (i > 1) tick();
            vectors++;
            if (busy1 !== 1'b1 || done1 !== 1'b0 || dout1 !== 32'h0) begin
                miscompares++;
                $display("FAIL sll_busy cycle %0d: busy=%b done=%b dout=%h, expected 1 0 00000000",
                         i, busy1, done1, dout1);
            end
        end
        tick();
        vectors++;
        if (done1 !== 1'b1 || busy1 !== 1'b0 || dout1 !== 32'h0000_0010) begin
            miscompares++;
            $display("FAIL sll_done: done=%b busy=%b dout=%h, expected 1 0 00000010",
                     done1, busy1, dout1);
        end
        tick();
        vectors++;
        if (done1 !== 1'b0 || dout1 !== 32'h0000_0010) begin
            miscompares++;
            $display("FAIL sll_hold: done=%b dout=%h, expected 0 00000010", done1, dout1);
        end
    endtask

    task automatic test_sra_srl();
        int e;
        go(1'b0, 2'b10, 5'd31, 32'h8000_0000);
        wait_done(1'b0, 1, e);
        vectors++;
        if (e !== 32 || dout1 !== 32'hFFFF_FFFF) begin
            miscompares++;
            $display("FAIL sra31: edge=%0d dout=%h, expected 32 FFFFFFFF", e, dout1);
        end
        tick();
        go(1'b0, 2'b01, 5'd31, 32'h8000_0000);
        wait_done(1'b0, 1, e);
        vectors++;
        if (e !== 32 || dout1 !== 32'h0000_0001) begin
            miscompares++;
            $display("FAIL srl31: edge=%0d dout=%h, expected 32 00000001", e, dout1);
        end
        tick();
    endtask

    task automatic test_step4();
        int e;
        go(1'b1, 2'b01, 5'd7, 32'hF000_0000);
        vectors++;
        if (busy4 !== 1'b1) begin
            miscompares++;
            $display("FAIL step4_busy: got %b, expected 1", busy4);
        end
        wait_done(1'b1, 1, e);
        vectors++;
        if (e !== 3 || dout4 !== 32'h01E0_0000) begin
            miscompares++;
            $display("FAIL step4_srl7: edge=%0d dout=%h, expected 3 01E00000", e, dout4);
        end
        tick();
    endtask

    task automatic test_rotr();
        int e;
        go(1'b0, 2'b11, 5'd8, 32'h1234_5678);
        wait_done(1'b0, 1, e);
        vectors++;
        if (e !== 9 || dout1 !== 32'h7812_3456) begin
            miscompares++;
            $display("FAIL rotr8: edge=%0d dout=%h, expected 9 78123456", e, dout1);
        end
        tick();
    endtask

    task automatic test_sa_zero();
        int e;
        go(1'b0, 2'b10, 5'd0, 32'hDEAD_BEEF);
        wait_done(1'b0, 1, e);
        vectors++;
        if (e !== 1 || dout1 !== 32'hDEAD_BEEF || busy1 !== 1'b0) begin
            miscompares++;
            $display("FAIL sa_zero: edge=%0d dout=%h busy=%b, expected 1 DEADBEEF 0", e, dout1, busy1);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        int e;
        go(1'b0, 2'b00, 5'd2, 32'h0000_0003);
        wait_done(1'b0, 1, e);
        vectors++;
        if (e !== 3 || dout1 !== 32'h0000_000C) begin
            miscompares++;
            $display("FAIL b2b_first: edge=%0d dout=%h, expected 3 0000000C", e, dout1);
        end
        // Second request presented during the done cycle.
        go(1'b0, 2'b01, 5'd1, 32'h0000_0080);
        vectors++;
        if (busy1 !== 1'b1 || done1 !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_accept: busy=%b done=%b, expected 1 0", busy1, done1);
        end
        tick();
        vectors++;
        if (done1 !== 1'b1 || dout1 !== 32'h0000_0040) begin
            miscompares++;
            $display("FAIL b2b_second: done=%b dout=%h, expected 1 00000040", done1, dout1);
        end
        tick();
    endtask

    task automatic test_ignore_start();
        int e;
        go(1'b0, 2'b00, 5'd10, 32'hA5A5_A5A5);
        tick();
        tick();
        op     = 2'b01;
        sa     = 5'd1;
        din    = 32'hFFFF_FFFF;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        wait_done(1'b0, 4, e);
        vectors++;
        if (e !== 11 || dout1 !== 32'h9696_9400) begin
            miscompares++;
            $display("FAIL ignore_start: edge=%0d dout=%h, expected 11 96969400", e, dout1);
        end
        tick();
        vectors++;
        if (busy1 !== 1'b0 || done1 !== 1'b0) begin
            miscompares++;
            $display("FAIL no_queue: busy=%b done=%b, expected 0 0", busy1, done1);
        end
    endtask

    task automatic test_flush();
        bit seen_done;
        go(1'b0, 2'b00, 5'd20, 32'h0000_0001);
        for (int i = 2; i <= 5; i++) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        vectors++;
        if (busy1 !== 1'b0 || done1 !== 1'b0 || dout1 !== 32'h9696_9400) begin
            miscompares++;
            $display("FAIL flush_abort: busy=%b done=%b dout=%h, expected 0 0 96969400",
                     busy1, done1, dout1);
        end
        seen_done = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (done1 === 1'b1 || busy1 === 1'b1) seen_done = 1'b1;
        end
        vectors++;
        if (seen_done !== 1'b0 || dout1 !== 32'h9696_9400) begin
            miscompares++;
            $display("FAIL flush_quiet: activity=%b dout=%h, expected 0 96969400", seen_done, dout1);
        end
    endtask

    task automatic test_reset_mid_op();
        int e;
        go(1'b0, 2'b00, 5'd20, 32'h0000_0001);
        tick();
        tick();
        resetn = 1'b0;
        #1;
        vectors++;
        if (busy1 !== 1'b0 || done1 !== 1'b0 || dout1 !== 32'h0) begin
            miscompares++;
            $display("FAIL async_reset: busy=%b done=%b dout=%h, expected 0 0 00000000",
                     busy1, done1, dout1);
        end
        tick();
        #2 resetn = 1'b1;
        tick();
        go(1'b0, 2'b00, 5'd1, 32'h0000_0001);
        wait_done(1'b0, 1, e);
        vectors++;
        if (e !== 2 || dout1 !== 32'h0000_0002) begin
            miscompares++;
            $display("FAIL post_reset: edge=%0d dout=%h, expected 2 00000002", e, dout1);
        end
        tick();
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        resetn      = 1'b0;
        start1      = 1'b0;
        start4      = 1'b0;
        flush       = 1'b0;
        op          = 2'b00;
        sa          = 5'd0;
        din         = 32'h0;
        test_reset();
        test_sll();
        test_sra_srl();
        test_step4();
        test_rotr();
        test_sa_zero();
        test_back_to_back();
        test_ignore_start();
        test_flush();
        test_reset_mid_op();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/serial_shift_unit.md
Name: serial_shift_unit

Overview:
- Multi-cycle shift unit in the EX stage of the multi-cycle MIPS datapath. It sits directly downstream of the shift-amount source (sa field or rs[4:0]) that feeds the combinational sll test block.
- Performs sll/srl/sra/rotr on a 32-bit operand at STEP bits per cycle, using a start/busy/done handshake toward the control FSM.
- The result is held until the next operation, for write-back via the EX/MEM latch.

Parameters:
- WIDTH, 32, operand/result width.
- SAW, 5, shift-amount width. Must equal log2(WIDTH).
- STEP, 1, bits shifted per cycle. Power of two, 1..WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- resetn  input  1  asynchronous, active-low reset.
- start  input  1  request. Sampled only in IDLE or DONE.
- op  input  2  operation: 00 sll, 01 srl, 10 sra, 11 rotr.
- sa  input  SAW  shift amount, latched on accepted start.
- din  input  WIDTH  operand, latched on accepted start.
- flush  input  1  synchronous abort from the pipeline control.
- busy  output  1  high while state==SHIFT.
- done  output  1  one-cycle pulse: result valid.
- dout  output  WIDTH  last completed result.

Behaviour:
- Reset (resetn=0, asynchronous):
  - State goes to IDLE.
  - busy=0, done=0, dout=0, internal acc=0, cnt=0.
  - Reset mid-operation discards the operation; no done pulse.
- States: IDLE, SHIFT, DONE.
- Accepted start, in IDLE or DONE, with flush=0:
  - acc<=din, cnt<=sa, op and sign bit latched.
  - sa==0: next state DONE.
  - Otherwise: next state SHIFT.
- SHIFT, each edge:
  - k = min(STEP, cnt).
  - acc is shifted by k per the latched op.
  - cnt <= cnt - k.
  - When the new cnt==0, next state is DONE.
- DONE:
  - dout is loaded with the final acc on the edge entering DONE.
  - done=1 for exactly that one cycle.
  - Next state is SHIFT/DONE if start is accepted, else IDLE.
  - Back-to-back operations therefore cost no idle cycle.
- Latency: done is high in the cycle after edge number 1+ceil(sa/STEP), counting the start edge as edge 1.
- start while busy is ignored. No queuing. The latched operands are unaffected.
- flush=1 has priority over start:
  - State goes to IDLE on the next edge; busy=0.
  - No done pulse.
  - dout keeps its previous value.
- Shift rules:
  - sll fills with 0 from the LSB side.
  - srl fills with 0 from the MSB side.
  - sra fills with bit WIDTH-1 of the latched din.
  - rotr rotates right.
  - Amounts are taken modulo WIDTH; sa can never exceed WIDTH-1.
- dout changes only on entry to DONE or on reset. It is stable in all other cycles.
- Inputs din, sa and op may change freely after acceptance.

Decomposition:
- Shared package/header shift_pkg holds:
  - op encodings: OP_SLL, OP_SRL, OP_SRA, OP_ROTR;
  - state encodings: ST_IDLE, ST_SHIFT, ST_DONE.
- One sub-module, shift_step: a combinational single-step shifter.
  - Inputs: acc, op, fill bit, k in 0..STEP.
  - Output: shifted acc.
  - Instantiated once in SHIFT datapath.
- The FSM, counter and registers live in serial_shift_unit.

Test Plan:
- STEP=1, op=sll, din=0x00000001, sa=4: busy high 4 cycles; done pulses after edge 5; dout=0x00000010.
- STEP=1, op=sra, din=0x80000000, sa=31: done after edge 32; dout=0xFFFFFFFF. Then op=srl with the same operands: dout=0x00000001.
- STEP=4, op=srl, din=0xF0000000, sa=7: 2 shift cycles; done after edge 3; dout=0x01E00000.
- STEP=1:
  - op=rotr, din=0x12345678, sa=8 → dout=0x78123456.
  - sa=0 → done after edge 1 with dout=din.
  - A second start asserted in the done cycle is accepted: no IDLE cycle.
- Operation in progress (sll din=0xA5A5A5A5 sa=10), start pulsed at cycle 3 with din=0xFFFFFFFF:
  - the second start is ignored;
  - result is 0x96969400.
- Abort mid-operation:
  - flush at cycle 5 of sa=20 → IDLE next edge, no done, dout unchanged;
  - repeat with resetn=0 mid-operation → busy/done/dout=0 immediately, without waiting for a clock edge.
